oled_spi_tx: RTL
================

Name: oled_spi_tx

Overview:
- Byte-level 4-wire SPI transmitter that sits directly under the SSD1306-class OLED driver's command/pixel sequencer.
- Accepts one byte plus a D/C flag per valid/ready handshake.
- Serialises the byte MSB-first onto sclk/sdin (SPI mode 0: sclk idles low, panel samples on the rising edge).
- Owns cs and dc; keeps cs low across multi-byte bursts until a byte flagged last has been sent.

Parameters:
- CLK_DIV, 4: system clocks per sclk half-period; legal range >= 1. With a 27 MHz clk, CLK_DIV=4 gives 3.375 MHz sclk.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to transmit
- tx_dc  input  1  D/C level for this byte (0 = command, 1 = pixel data)
- tx_last  input  1  raise cs after this byte
- tx_valid  input  1  byte offered
- tx_ready  output  1  block can accept a byte this cycle
- sclk  output  1  SPI clock to OLED d0
- sdin  output  1  SPI data to OLED d1
- dc  output  1  D/C to OLED
- cs  output  1  chip select to OLED, active low
- busy  output  1  high whenever cs is low or state is not IDLE

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Registered outputs: all outputs are registered; no combinational path from any input to any output.
- Reset values (applied asynchronously, immediately): sclk=0, sdin=0, dc=0, cs=1, tx_ready=0, busy=0. State goes to IDLE.
- Reset release: tx_ready=1 after the first clk edge following rst_n release.
- Handshake: a byte is accepted on a clk edge where tx_valid && tx_ready.
  - Accept latches tx_data, tx_dc and tx_last internally and drives tx_ready to 0 at that same edge.
  - Input changes after accept have no effect.
  - tx_valid without tx_ready is ignored; no queuing.
- States and transitions:
  - IDLE: cs=1, sclk=0, tx_ready=1. On accept: cs<=0, dc<=tx_dc, sdin<=tx_data[7], bit counter<=7, go to LOW.
  - LOW: sclk=0 for CLK_DIV cycles, then sclk<=1 and go to HIGH.
  - HIGH: sclk=1 for CLK_DIV cycles.
    - If bit counter > 0: sclk<=0, shift, sdin<=next lower bit, decrement, go to LOW.
    - If bit counter = 0: sclk<=0. Go to HOLD if the latched last flag is set, otherwise go to GAP.
  - HOLD: cs low, sclk 0 for CLK_DIV cycles, then cs<=1, tx_ready<=1, go to IDLE.
  - GAP: cs stays 0, sclk 0, sdin holds bit 0, tx_ready=1, waits indefinitely. On accept: dc<=tx_dc, sdin<=tx_data[7], go to LOW (no cs toggle).
- Single-byte timing, accept at edge T, N = CLK_DIV:
  - Rising sclk edges at T+N+2Nk for k=0..7.
  - Final fall at T+16N.
  - With last: cs rises at T+17N; next accept is possible at T+17N+1, so cs is high for at least 1 cycle.
- Data and dc stability: sdin changes only together with a falling sclk, or at accept while sclk is low. dc changes only at accept, while sclk is low.
- Counters: the half-period counter is wide enough for CLK_DIV-1 ($clog2, minimum 1 bit) and wraps to 0 at every phase change. The 3-bit bit counter has no wrap-around.
- Mid-operation reset: reset at any point aborts the transfer. cs=1 and sclk=0 take effect immediately; no further sclk edges occur until a new accept.

Test Plan:
- Single byte, CLK_DIV=4: 0xA5, dc=0, last=1 -> sdin sampled at the 8 sclk rises (T+4, T+12 … T+60) = 1,0,1,0,0,1,0,1. Also: cs low T..T+68, dc=0 throughout, tx_ready back to 1 at T+68.
- Burst: 0xAE (dc=0, last=0), then 0x3C (dc=1, last=1) offered on the first GAP cycle -> cs low continuously, exactly 16 sclk rises, dc=0 for the first 8 rises and 1 for the last 8, cs rises once at the end.
- Handshake isolation: hold tx_valid=1 and change tx_data every cycle during a transfer -> no capture while tx_ready=0; transmitted bits equal the originally accepted byte.
- GAP stall: 0x81 with last=0, then tx_valid withheld 20 cycles -> cs=0, sclk=0, tx_ready=1, busy=1 for all 20 cycles. A later 0x00 with last=1 is sent, then cs rises.
- Async reset at the 4th rising edge of 0xF0 -> same instant cs=1, sclk=0, sdin=0, tx_ready=0. One cycle after release tx_ready=1; no sclk activity until the next accept.
- CLK_DIV=1: 0xFF, last=1 -> sclk period 2 cycles, sdin=1 at all 8 rises, cs rises at T+17.

Source files
------------

// File: rtl/oled_spi_tx.sv
// Byte-level 4-wire SPI transmitter (mode 0, MSB first) for an SSD1306-class OLED.
// Holds cs low across a burst until a byte flagged last has been shifted out.
module oled_spi_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sclk,
  output logic       sdin,
  output logic       dc,
  output logic       cs,
  output logic       busy
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {StIdle, StLow, StHigh, StHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sr_q, sr_d;
  logic            last_q, last_d;
  logic            sclk_q, sclk_d;
  logic            sdin_q, sdin_d;
  logic            dc_q, dc_d;
  logic            cs_q, cs_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic accept;
  logic phase_end;

  assign accept    = tx_valid && ready_q;
  assign phase_end = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    dc_d    = dc_q;
    cs_d    = cs_q;
    ready_d = ready_q;

    unique case (state_q)
      StIdle, StGap: begin
        sclk_d  = 1'b0;
        ready_d = 1'b1;
        if (state_q == StIdle) begin
          cs_d = 1'b1;
        end
        if (accept) begin
          // A GAP accept keeps cs low so the burst continues without a cs toggle.
          cs_d    = 1'b0;
          dc_d    = tx_dc;
          sdin_d  = tx_data[7];
          sr_d    = tx_data;
          last_d  = tx_last;
          bit_d   = 3'd7;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = StLow;
        end
      end
      StLow: begin
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHigh: begin
        if (phase_end) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != 3'd0) begin
            sr_d    = {sr_q[6:0], 1'b0};
            sdin_d  = sr_q[6];
            bit_d   = bit_q - 3'd1;
            state_d = StLow;
          end else begin
            state_d = last_q ? StHold : StGap;
            ready_d = !last_q;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (phase_end) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle) || !cs_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdin_q  <= 1'b0;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      dc_q    <= dc_d;
      cs_q    <= cs_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_ready = ready_q;
  assign sclk     = sclk_q;
  assign sdin     = sdin_q;
  assign dc       = dc_q;
  assign cs       = cs_q;
  assign busy     = busy_q;

endmodule
